// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller: wait states, word array,
// registered read data and a one-cycle done/err completion pulse.
module dmem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_INIT =
    (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic wr_q, wr_d;
  logic err_q, err_d;
  logic [31:0] rdata_q;

  logic [31:0] mem [2**ADDR_W];

  logic req, bad_req, good_req;
  logic addr_unused;

  // Upper address bits alias by design.
  assign addr_unused = ^addr[31:ADDR_W+2];

  assign req = req_rd | req_wr;
  assign bad_req = req &
    ((addr[1:0] != 2'b00) | (req_rd & req_wr));
  assign good_req = req & ~bad_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          bad_req: begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
          good_req: begin
            state_d = (WAIT > 0) ? S_WAIT : S_ACCESS;
            cnt_d   = CNT_INIT;
            idx_d   = addr[ADDR_W+1:2];
            wdata_d = wdata;
            wr_d    = req_wr;
            err_d   = 1'b0;
          end
          default: ;
        endcase
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else cnt_d = cnt_q - 4'd1;
      end
      S_ACCESS: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      if (state_q == S_ACCESS && !wr_q)
        rdata_q <= mem[idx_q];
    end
  end

  // Array has no reset; reset before ACCESS abandons the write.
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS && wr_q)
      mem[idx_q] <= wdata_q;
  end

  assign rdata = rdata_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign err   = err_q & (state_q == S_DONE);

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Multi-cycle data-memory controller for the bus-based multi-cycle CPU. It sits directly downstream of the MAR/MDR registers and replaces the single-cycle combinational data memory. The controller accepts a read or write request from the microprogrammed control unit, inserts a configurable number of wait states, and performs the access on an internal word array. It then returns read data with a one-cycle `done` pulse, so the control unit can stall in a memory-wait microstate instead of assuming zero-latency memory.

## Interface
Parameters:
- `ADDR_W`, default 8: word-address width; the array holds 2^ADDR_W 32-bit words.
- `WAIT`, default 2: wait-state cycles inserted before each access; legal range 0–15.

Ports:
- `clk`  in  1: single system clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req_rd`  in  1: read request (driven by MemRd), sampled only in IDLE.
- `req_wr`  in  1: write request (driven by MemWr), sampled only in IDLE.
- `addr`  in  32: byte address, taken from the MAR output.
- `wdata`  in  32: write data, taken from the MDR output.
- `rdata`  out  32: read data; drives the MDR load mux and the bus tristate.
- `busy`  out  1: high whenever the controller is not in IDLE.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: qualifies `done`; marks a rejected request.

## Operation
- States: IDLE, WAIT, ACCESS, DONE. All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- **IDLE**
  - A request is present when `req_rd | req_wr`.
  - Request is illegal if `addr[1:0] != 0` or `req_rd & req_wr`. Illegal request: → DONE with `err` set, no array access.
  - Legal request: latch `addr`, `wdata` and the operation. Go to WAIT if `WAIT > 0`, else to ACCESS. Load the wait counter with `WAIT - 1`.
- **WAIT**: decrement the counter each edge; → ACCESS on the edge where the counter is 0. Inputs are ignored.
- **ACCESS**: on one edge, perform the array operation at word index `addr_latched[ADDR_W+1:2]`, then → DONE.
  - Write: the array is written; `rdata` is unchanged.
  - Read: `rdata` is loaded with the array word.
- **DONE**: `done = 1` for exactly one cycle, with `err` as set for this request. → IDLE on the next edge. Requests presented during DONE are ignored because `busy` is high.
- Address bits above `ADDR_W+1` are ignored, so addresses alias with wrap-around modulo 4·2^ADDR_W bytes.
- `rdata` holds the last successful read value until the next successful read completes. Writes and errors never change it.
- Requests while `busy` is high are dropped, not queued. The requester must hold `req_*` until it sees `busy`, and must deassert it before DONE ends.

## Timing
- Reset values:
  - state IDLE;
  - `rdata` = 0;
  - `busy` = 0, `done` = 0, `err` = 0;
  - wait counter = 0;
  - array contents not initialised (X in simulation).
- Let E0 be the edge that samples a legal request.
  - `busy` is high from E0.
  - The array is updated at edge E0+WAIT+1.
  - `done` is high in the cycle after E0+WAIT+1.
  - With `WAIT = 2`, `done` is high after E3.
- Illegal request: `done` and `err` are high in the cycle after E0.
- Minimum request-to-request spacing: WAIT+3 edges for legal requests, 2 edges for illegal requests.
- Asserting reset mid-operation returns to IDLE immediately.
  - If reset hits before the ACCESS edge, the write is abandoned and the array is unchanged.
  - `done` never pulses for an aborted request.
- `rdata` is stable from the `done` cycle until the next read's ACCESS edge.

## Test plan
- `WAIT=2`: write `0xDEADBEEF` at `0x10`, then read `0x10` → `rdata = 0xDEADBEEF`. Each `done` is high in the cycle after E3. `busy` is high for 4 cycles per request.
- Read at `0x13` → `done` and `err` high in the cycle after E0. A following read at `0x10` still returns `0xDEADBEEF`; `rdata` is unchanged by the error.
- `req_rd = req_wr = 1` at `0x20` → error pulse. A later read of `0x20` returns the previously written `0x12345678`.
- `ADDR_W=8`: write `0xCAFE0001` at `0x400` → a read at `0x000` returns `0xCAFE0001` (aliasing).
- Write `0x55AA55AA` at `0x08` over existing `0x11111111`, with reset asserted during WAIT → state IDLE, `done` never pulses, and a read of `0x08` returns `0x11111111`.
- `WAIT=0`: read presented while `busy` is high → ignored. The first read's `done` is high in the cycle after E1, and exactly one `done` pulse occurs.
